io_sequencer: RTL

IO_SEQUENCER -- requirements
Module: io_sequencer

---
 rtl/io_pkg.sv | 31 +++
 rtl/io_debounce.sv | 68 ++++++
 rtl/io_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// io_pkg -- shared types and constants for the IO sequencer.
//   io_state_t  : sequencer FSM states
//   disp_mode_t : display mode encodings driven to the 7-segment front end
//   DEBOUNCE_CYCLES_DEFAULT : default Enter debounce length in clk cycles
//   sw_word()   : zero-extends the slide switches to a 32-bit data word
package io_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
   localparam int unsigned SW_W   = 10;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_WAIT_PRESS   = 3'd1,
      ST_WAIT_RELEASE = 3'd2,
      ST_ACK          = 3'd3,
      ST_HALT         = 3'd4
   } io_state_t;

   typedef enum logic [1:0] {
      DISP_DASH   = 2'd0,
      DISP_INPUT  = 2'd1,
      DISP_OUTPUT = 2'd2,
      DISP_HALT   = 2'd3
   } disp_mode_t;

   function automatic logic [DATA_W-1:0] sw_word(input logic [SW_W-1:0] sw);
      return {{(DATA_W-SW_W){1'b0}}, sw};
   endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce -- synchronizer and debouncer for the active-low Enter button.
//   clk           : system clock
//   reset         : asynchronous active-low reset
//   enter_n       : raw button, asynchronous to clk
//   level         : debounced level (1 = released)
//   press         : one-cycle pulse when level goes 1 -> 0
//   release_edge  : one-cycle pulse when level goes 0 -> 1
module io_debounce
   import io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic enter_n,
   output logic level,
   output logic press,
   output logic release_edge
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam bit SINGLE = (DEBOUNCE_CYCLES <= 1);

   logic             sync_1;
   logic             sync_2;
   logic [CNT_W-1:0] cnt;
   logic             mismatch;
   logic             accept;

   // cnt is a down-counter of remaining mismatching samples; 0 means no
   // mismatch run is in progress, so the first mismatch loads the reload
   // value (that sample already counts as one) and terminal count is 1.
   always_comb begin
      mismatch = sync_2 ^ level;
      accept   = mismatch && (SINGLE || (cnt == CNT_ONE));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_1       <= 1'b1;
         sync_2       <= 1'b1;
         level        <= 1'b1;
         cnt          <= '0;
         press        <= 1'b0;
         release_edge <= 1'b0;
      end else begin
         sync_1       <= enter_n;
         sync_2       <= sync_1;
         press        <= 1'b0;
         release_edge <= 1'b0;
         if (!mismatch) begin
            cnt <= '0;
         end else if (accept) begin
            level        <= sync_2;
            cnt          <= '0;
            press        <= ~sync_2;
            release_edge <= sync_2;
         end else if (cnt == '0) begin
            cnt <= CNT_RELOAD;
         end else begin
            cnt <= cnt - CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/io_sequencer.sv
// io_sequencer -- sequences CPU IN/OUT/HALT instructions against the Enter
// button, slide switches and 7-segment display.
//   clk, reset         : system clock, asynchronous active-low reset
//   in_req             : CPU executing IN (level, held until in_ack)
//   out_req            : CPU executing OUT (single-cycle qualifier)
//   halt_req           : CPU executing HALT
//   enter_n            : raw Enter button, active-low
//   sw                 : slide switches
//   out_data           : OUT operand
//   stall              : CPU must hold PC and pipeline
//   in_ack, in_data    : IN completion pulse and captured switch word
//   disp_mode          : 0 dashes, 1 input echo, 2 output value, 3 halt banner
//   disp_value         : value for the 7-segment decoder
//   halted             : sticky halt indication
//
// state           | meaning
// ----------------+---------------------------------------------------------
// ST_IDLE         | no request in progress; OUT updates display in place
// ST_WAIT_PRESS   | IN pending, echoing switches, waiting for a fresh press
// ST_WAIT_RELEASE | value captured, waiting for button release
// ST_ACK          | one-cycle in_ack, CPU released
// ST_HALT         | absorbing until reset
module io_sequencer
   import io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_req,
   input  logic              out_req,
   input  logic              halt_req,
   input  logic              enter_n,
   input  logic [SW_W-1:0]   sw,
   input  logic [DATA_W-1:0] out_data,
   output logic              stall,
   output logic              in_ack,
   output logic [DATA_W-1:0] in_data,
   output logic [1:0]        disp_mode,
   output logic [DATA_W-1:0] disp_value,
   output logic              halted
);

   io_state_t         state;
   io_state_t         state_nxt;
   disp_mode_t        disp_mode_q;
   disp_mode_t        disp_mode_nxt;
   logic [DATA_W-1:0] in_data_nxt;
   logic [DATA_W-1:0] disp_value_nxt;
   logic              db_level;
   logic              db_press;
   logic              db_release;
   logic              press_ok;
   logic              release_ok;

   io_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk          (clk),
      .reset        (reset),
      .enter_n      (enter_n),
      .level        (db_level),
      .press        (db_press),
      .release_edge (db_release)
   );

   // Events are qualified with the settled level so only a completed
   // transition is acted on. A press already held on entry to WAIT_PRESS
   // produced its pulse earlier and is therefore ignored.
   assign press_ok   = db_press & ~db_level;
   assign release_ok = db_release & db_level;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         in_data     <= '0;
         disp_mode_q <= DISP_DASH;
         disp_value  <= '0;
      end else begin
         state       <= state_nxt;
         in_data     <= in_data_nxt;
         disp_mode_q <= disp_mode_nxt;
         disp_value  <= disp_value_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      in_data_nxt    = in_data;
      disp_mode_nxt  = disp_mode_q;
      disp_value_nxt = disp_value;

      if (halt_req && (state != ST_HALT)) begin
         state_nxt     = ST_HALT;
         disp_mode_nxt = DISP_HALT;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_req) begin
                  state_nxt      = ST_WAIT_PRESS;
                  disp_mode_nxt  = DISP_INPUT;
                  disp_value_nxt = sw_word(sw);
               end else if (out_req) begin
                  disp_mode_nxt  = DISP_OUTPUT;
                  disp_value_nxt = out_data;
               end
            end
            ST_WAIT_PRESS: begin
               if (!in_req) begin
                  state_nxt = ST_IDLE;
               end else if (press_ok) begin
                  state_nxt      = ST_WAIT_RELEASE;
                  in_data_nxt    = sw_word(sw);
                  disp_value_nxt = sw_word(sw);
               end else begin
                  disp_value_nxt = sw_word(sw);
               end
            end
            ST_WAIT_RELEASE: begin
               if (!in_req) begin
                  state_nxt = ST_IDLE;
               end else if (release_ok) begin
                  state_nxt = ST_ACK;
               end
            end
            ST_ACK: begin
               state_nxt = ST_IDLE;
            end
            ST_HALT: begin
               state_nxt     = ST_HALT;
               disp_mode_nxt = DISP_HALT;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign stall = ((state == ST_IDLE) && in_req && !halt_req) ||
                  (state == ST_WAIT_PRESS)   ||
                  (state == ST_WAIT_RELEASE) ||
                  (state == ST_HALT);

   assign in_ack    = (state == ST_ACK);
   assign halted    = (state == ST_HALT);
   assign disp_mode = disp_mode_q;

endmodule
